// File: rtl/result_axi_pkg.sv
// Shared constants, FSM state type and strobe helper for the result AXI writer.
// Optional response checking is enabled with RESULT_AXI_WRITER_BRESP_CHECK_EN.
package result_axi_pkg;

  localparam int          DATA_W       = 512;
  localparam int          BEAT_BYTES   = 64;
  localparam int          STRB_W       = DATA_W / 8;
  localparam logic [2:0]  AXSIZE_64B   = 3'd6;
  localparam logic [1:0]  AXBURST_INCR = 2'b01;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_RESP,
    ST_DONE
  } state_e;

  // Byte enables for the final beat; a zero tail means the beat is full.
  function automatic logic [STRB_W-1:0] tail_strb(input logic [5:0] tail);
    logic [STRB_W-1:0] one;
    one = {{(STRB_W-1){1'b0}}, 1'b1};
    return (tail == 6'd0) ? {STRB_W{1'b1}} : ((one << tail) - one);
  endfunction

endpackage

// File: rtl/result_axi_burst_len.sv
// Burst length calculator: min(remaining beats, MAX_BURST, beats left before
// the next 4 KB boundary). Purely combinational.
module result_axi_burst_len #(
  parameter int MAX_BURST = 64
) (
  input  logic [63:0] remaining,
  input  logic [5:0]  addr_blk,   // address bits [11:6]: 64 B block within the 4 KB page
  output logic [8:0]  len
);

  logic [6:0] to_4k;
  logic [8:0] cap;

  always_comb begin
    to_4k = 7'd64 - {1'b0, addr_blk};
    cap   = (9'(MAX_BURST) < {2'b00, to_4k}) ? 9'(MAX_BURST) : {2'b00, to_4k};
    len   = (remaining < 64'(cap)) ? remaining[8:0] : cap;
  end

endmodule

// File: rtl/result_axi_writer.sv
// Writes a 512-bit result stream to host memory as 4 KB-safe AXI4 INCR bursts.
// Define RESULT_AXI_WRITER_BRESP_CHECK_EN to add m_axi_bresp and a sticky wr_error.
module result_axi_writer
  import result_axi_pkg::*;
#(
  parameter int MAX_BURST = 64,
  parameter int ADDR_W    = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ctrl_start,
  output logic              ctrl_done,
  input  logic [ADDR_W-1:0] ctrl_addr_offset,
  input  logic [63:0]       ctrl_xfer_size_in_bytes,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic [DATA_W-1:0] s_axis_tdata,
  output logic              m_axi_awvalid,
  input  logic              m_axi_awready,
  output logic [ADDR_W-1:0] m_axi_awaddr,
  output logic [7:0]        m_axi_awlen,
  output logic [2:0]        m_axi_awsize,
  output logic [1:0]        m_axi_awburst,
  output logic              m_axi_wvalid,
  input  logic              m_axi_wready,
  output logic [DATA_W-1:0] m_axi_wdata,
  output logic [STRB_W-1:0] m_axi_wstrb,
  output logic              m_axi_wlast,
  input  logic              m_axi_bvalid,
  output logic              m_axi_bready
`ifdef RESULT_AXI_WRITER_BRESP_CHECK_EN
  ,
  input  logic [1:0]        m_axi_bresp,
  output logic              wr_error
`endif
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [63:0]       remaining_q, remaining_d;
  logic [5:0]        tail_q, tail_d;
  logic [7:0]        awlen_q, awlen_d;
  logic [7:0]        beat_q, beat_d;
  logic              done_q, done_d;
  logic [8:0]        len_next;
  logic [8:0]        len_cur;

  // Fed from the next-state values so the length is ready the cycle ADDR is entered.
  result_axi_burst_len #(.MAX_BURST(MAX_BURST)) u_burst_len (
    .remaining (remaining_d),
    .addr_blk  (addr_d[11:6]),
    .len       (len_next)
  );

  assign len_cur       = {1'b0, awlen_q} + 9'd1;
  assign m_axi_awaddr  = addr_q;
  assign m_axi_awlen   = awlen_q;
  assign m_axi_awsize  = AXSIZE_64B;
  assign m_axi_awburst = AXBURST_INCR;
  assign m_axi_wdata   = s_axis_tdata;
  assign ctrl_done     = done_q;

  // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    remaining_d   = remaining_q;
    tail_d        = tail_q;
    awlen_d       = awlen_q;
    beat_d        = beat_q;
    done_d        = 1'b0;
    m_axi_awvalid = 1'b0;
    m_axi_wvalid  = 1'b0;
    s_axis_tready = 1'b0;
    m_axi_bready  = 1'b0;
    m_axi_wlast   = (state_q == ST_DATA) && (beat_q == awlen_q);
    m_axi_wstrb   = (m_axi_wlast && (remaining_q == 64'(len_cur))) ? tail_strb(tail_q)
                                                                   : {STRB_W{1'b1}};

    unique case (state_q)
      ST_IDLE: begin
        if (ctrl_start) begin
          addr_d      = ctrl_addr_offset & ~ADDR_W'(BEAT_BYTES - 1);
          remaining_d = {6'd0, ctrl_xfer_size_in_bytes[63:6]}
                        + 64'(|ctrl_xfer_size_in_bytes[5:0]);
          tail_d      = ctrl_xfer_size_in_bytes[5:0];
          state_d     = (ctrl_xfer_size_in_bytes == 64'd0) ? ST_DONE : ST_ADDR;
        end
      end
      ST_ADDR: begin
        m_axi_awvalid = 1'b1;
        beat_d        = 8'd0;
        if (m_axi_awready) state_d = ST_DATA;
      end
      ST_DATA: begin
        m_axi_wvalid  = s_axis_tvalid;
        s_axis_tready = m_axi_wready;
        if (s_axis_tvalid && m_axi_wready) begin
          beat_d = beat_q + 8'd1;
          if (m_axi_wlast) state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        m_axi_bready = 1'b1;
        if (m_axi_bvalid) begin
          addr_d      = addr_q + (ADDR_W'(len_cur) << 6);
          remaining_d = remaining_q - 64'(len_cur);
          state_d     = (remaining_d != 64'd0) ? ST_ADDR : ST_DONE;
        end
      end
      ST_DONE: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Length is latched only on ADDR entry so awlen stays stable while awvalid is high.
    if ((state_d == ST_ADDR) && (state_q != ST_ADDR)) awlen_d = 8'(len_next - 9'd1);
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      tail_q      <= '0;
      awlen_q     <= '0;
      beat_q      <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      tail_q      <= tail_d;
      awlen_q     <= awlen_d;
      beat_q      <= beat_d;
      done_q      <= done_d;
    end
  end

`ifdef RESULT_AXI_WRITER_BRESP_CHECK_EN
  logic wr_error_q, wr_error_d;

  always_comb begin
    wr_error_d = wr_error_q;
    if ((state_q == ST_IDLE) && ctrl_start) wr_error_d = 1'b0;
    if ((state_q == ST_RESP) && m_axi_bvalid && (m_axi_bresp != 2'b00)) wr_error_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) wr_error_q <= 1'b0;
    else          wr_error_q <= wr_error_d;
  end

  assign wr_error = wr_error_q;
`endif

endmodule

// File: tb/tb_result_axi_writer.sv
// Directed bench for result_axi_writer: AXI slave and stream source models,
// handshake monitor, and hand-computed expectations per command.
module tb_result_axi_writer;
  import result_axi_pkg::*;

  localparam int ADDR_W = 64;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              ctrl_start;
  logic              ctrl_done;
  logic [ADDR_W-1:0] ctrl_addr_offset;
  logic [63:0]       ctrl_xfer_size_in_bytes;
  logic              s_axis_tvalid;
  logic              s_axis_tready;
  logic [DATA_W-1:0] s_axis_tdata;
  logic              m_axi_awvalid, m_axi_awready;
  logic [ADDR_W-1:0] m_axi_awaddr;
  logic [7:0]        m_axi_awlen;
  logic [2:0]        m_axi_awsize;
  logic [1:0]        m_axi_awburst;
  logic              m_axi_wvalid, m_axi_wready;
  logic [DATA_W-1:0] m_axi_wdata;
  logic [STRB_W-1:0] m_axi_wstrb;
  logic              m_axi_wlast;
  logic              m_axi_bvalid, m_axi_bready;
`ifdef RESULT_AXI_WRITER_BRESP_CHECK_EN
  logic [1:0]        m_axi_bresp = 2'b00;
  logic              wr_error;
`endif

  result_axi_writer #(.MAX_BURST(64), .ADDR_W(ADDR_W)) dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .ctrl_start              (ctrl_start),
    .ctrl_done               (ctrl_done),
    .ctrl_addr_offset        (ctrl_addr_offset),
    .ctrl_xfer_size_in_bytes (ctrl_xfer_size_in_bytes),
    .s_axis_tvalid           (s_axis_tvalid),
    .s_axis_tready           (s_axis_tready),
    .s_axis_tdata            (s_axis_tdata),
    .m_axi_awvalid           (m_axi_awvalid),
    .m_axi_awready           (m_axi_awready),
    .m_axi_awaddr            (m_axi_awaddr),
    .m_axi_awlen             (m_axi_awlen),
    .m_axi_awsize            (m_axi_awsize),
    .m_axi_awburst           (m_axi_awburst),
    .m_axi_wvalid            (m_axi_wvalid),
    .m_axi_wready            (m_axi_wready),
    .m_axi_wdata             (m_axi_wdata),
    .m_axi_wstrb             (m_axi_wstrb),
    .m_axi_wlast             (m_axi_wlast),
    .m_axi_bvalid            (m_axi_bvalid),
    .m_axi_bready            (m_axi_bready)
`ifdef RESULT_AXI_WRITER_BRESP_CHECK_EN
    ,
    .m_axi_bresp             (m_axi_bresp),
    .wr_error                (wr_error)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  function automatic logic [DATA_W-1:0] pat(input logic [7:0] id, input int k);
    return {16{id, k[23:0]}};
  endfunction

  // Bench state: slave/source knobs and monitor log
  int          cyc = 0;
  bit          rnd = 1'b0;
  bit          src_en = 1'b1;
  int          src_idx = 0;
  int          pend_b = 0;
  logic [7:0]  tx_id = 8'd1;
  logic        hs_aw = 1'b0, hs_w = 1'b0, hs_wlast = 1'b0, hs_b = 1'b0, hs_t = 1'b0;
  logic [63:0] aw_addr_log[$];
  logic [7:0]  aw_len_log[$];
  int          wlast_idx[$];
  int          beat_cnt, s_cnt, data_err, len_err, attr_err, viol, done_cnt, done_cyc, burst_beats;
  logic [7:0]  cur_awlen;
  logic        aw_out;
  logic [63:0] last_strb;
  int          start_cyc;

  always @(posedge clk) cyc++;

  // Monitor: at negedge, inputs and outputs are stable for the coming posedge
  always @(negedge clk) begin
    hs_aw    = m_axi_awvalid && m_axi_awready;
    hs_w     = m_axi_wvalid && m_axi_wready;
    hs_wlast = hs_w && m_axi_wlast;
    hs_b     = m_axi_bvalid && m_axi_bready;
    hs_t     = s_axis_tvalid && s_axis_tready;
    if (reset_n) begin
      if (hs_aw) begin
        aw_addr_log.push_back(m_axi_awaddr);
        aw_len_log.push_back(m_axi_awlen);
        if (m_axi_awsize != 3'd6 || m_axi_awburst != 2'b01) attr_err++;
        if (aw_out) viol++;
        aw_out      = 1'b1;
        cur_awlen   = m_axi_awlen;
        burst_beats = 0;
      end
      if (hs_t) s_cnt++;
      if (hs_w) begin
        if (m_axi_wdata !== pat(tx_id, beat_cnt)) data_err++;
        last_strb = m_axi_wstrb;
        burst_beats++;
        if (m_axi_wlast) begin
          wlast_idx.push_back(beat_cnt);
          if (burst_beats != int'(cur_awlen) + 1) len_err++;
        end
        beat_cnt++;
      end
      if (hs_b) aw_out = 1'b0;
      if (ctrl_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  // Slave and stream source, driven just after the active edge
  always @(posedge clk) begin
    #1;
    if (!reset_n) pend_b = 0;
    else begin
      if (hs_wlast) pend_b++;
      if (hs_b) pend_b--;
    end
    m_axi_bvalid  = (pend_b > 0);
    m_axi_awready = rnd ? ($urandom_range(0, 2) == 0) : 1'b1;
    m_axi_wready  = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
    if (hs_t && reset_n) src_idx++;
    if (!s_axis_tvalid || hs_t) s_axis_tvalid = src_en && (rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
    s_axis_tdata = pat(tx_id, src_idx);
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_log();
    tx_id++;
    aw_addr_log.delete();
    aw_len_log.delete();
    wlast_idx.delete();
    beat_cnt = 0; s_cnt = 0; data_err = 0; len_err = 0; attr_err = 0; viol = 0;
    done_cnt = 0; done_cyc = 0; burst_beats = 0; cur_awlen = 8'd0; aw_out = 1'b0;
    last_strb = 64'd0; src_idx = 0;
    s_axis_tdata = pat(tx_id, 0);
  endtask

  task automatic run_cmd(input logic [63:0] addr, input logic [63:0] size);
    ctrl_addr_offset        = addr;
    ctrl_xfer_size_in_bytes = size;
    ctrl_start              = 1'b1;
    start_cyc               = cyc;
    step();
    ctrl_start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      step();
      n++;
    end
    repeat (6) step();
  endtask

  task automatic check_aw(input string tag, input int i, input logic [63:0] addr, input logic [7:0] len);
    check($sformatf("%s_awaddr%0d", tag, i), (i < aw_addr_log.size()) ? aw_addr_log[i] : '1, addr);
    check($sformatf("%s_awlen%0d", tag, i), (i < aw_len_log.size()) ? 64'(aw_len_log[i]) : '1, 64'(len));
  endtask

  task automatic check_common(input string tag, input int bursts, input int beats);
    check({tag, "_aw_cnt"}, 64'(aw_addr_log.size()), 64'(bursts));
    check({tag, "_beats"}, 64'(beat_cnt), 64'(beats));
    check({tag, "_stream_beats"}, 64'(s_cnt), 64'(beats));
    check({tag, "_data_err"}, 64'(data_err), 64'd0);
    check({tag, "_len_err"}, 64'(len_err), 64'd0);
    check({tag, "_attr_err"}, 64'(attr_err), 64'd0);
    check({tag, "_outstanding"}, 64'(viol), 64'd0);
    check({tag, "_done_cnt"}, 64'(done_cnt), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    ctrl_start = 1'b0;
    ctrl_addr_offset = '0;
    ctrl_xfer_size_in_bytes = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tdata = '0;
    m_axi_awready = 1'b0;
    m_axi_wready = 1'b0;
    m_axi_bvalid = 1'b0;
    clear_log();
    repeat (3) step();
    check("rst_valids", 64'({m_axi_awvalid, m_axi_wvalid, s_axis_tready, m_axi_bready, ctrl_done}), 64'd0);
    check("rst_awaddr", m_axi_awaddr, 64'd0);
    check("rst_awlen", 64'(m_axi_awlen), 64'd0);
    reset_n = 1'b1;
    repeat (2) step();

    // T1: 16 KB from 0, four full 64-beat bursts
    clear_log();
    run_cmd(64'h0, 64'd16384);
    wait_done(3000);
    check_common("t1", 4, 256);
    for (int i = 0; i < 4; i++) check_aw("t1", i, 64'(i) * 64'h1000, 8'd63);
    check("t1_wlast_cnt", 64'(wlast_idx.size()), 64'd4);
    check("t1_last_strb", last_strb, 64'hFFFF_FFFF_FFFF_FFFF);

    // T2: 256 B straddling a 4 KB boundary
    clear_log();
    run_cmd(64'hF80, 64'd256);
    wait_done(500);
    check_common("t2", 2, 4);
    check_aw("t2", 0, 64'hF80, 8'd1);
    check_aw("t2", 1, 64'h1000, 8'd1);
    check("t2_wlast_cnt", 64'(wlast_idx.size()), 64'd2);
    check("t2_wlast0", (wlast_idx.size() > 0) ? 64'(wlast_idx[0]) : '1, 64'd1);
    check("t2_wlast1", (wlast_idx.size() > 1) ? 64'(wlast_idx[1]) : '1, 64'd3);

    // T3: 100 B, unaligned offset is forced down to 64 B, partial tail strobe
    clear_log();
    run_cmd(64'h2025, 64'd100);
    wait_done(500);
    check_common("t3", 1, 2);
    check_aw("t3", 0, 64'h2000, 8'd1);
    check("t3_last_strb", last_strb, 64'h0000_000F_FFFF_FFFF);

    // T4: zero-size command completes without bus traffic
    clear_log();
    run_cmd(64'h5000, 64'd0);
    wait_done(50);
    check("t4_aw_cnt", 64'(aw_addr_log.size()), 64'd0);
    check("t4_beats", 64'(beat_cnt), 64'd0);
    check("t4_done_cnt", 64'(done_cnt), 64'd1);
    check("t4_done_latency", 64'(done_cyc - start_cyc), 64'd2);

    // T5: random back-pressure and gaps, plus an ignored second start
    rnd = 1'b1;
    clear_log();
    run_cmd(64'h40, 64'd4500);
    for (int n = 0; n < 2000 && beat_cnt < 10; n++) step();
    run_cmd(64'h8000, 64'd64);
    wait_done(4000);
    check_common("t5", 2, 71);
    check_aw("t5", 0, 64'h40, 8'd62);
    check_aw("t5", 1, 64'h1000, 8'd7);
    check("t5_wlast0", (wlast_idx.size() > 0) ? 64'(wlast_idx[0]) : '1, 64'd62);
    check("t5_wlast1", (wlast_idx.size() > 1) ? 64'(wlast_idx[1]) : '1, 64'd70);
    check("t5_last_strb", last_strb, 64'h0000_0000_000F_FFFF);
    rnd = 1'b0;
    repeat (4) step();

    // T6: reset in the middle of a data phase, then a clean 128 B transfer
    clear_log();
    run_cmd(64'h0, 64'd16384);
    for (int n = 0; n < 500 && beat_cnt < 5; n++) step();
    check("t6_in_data", 64'(m_axi_wvalid), 64'd1);
    reset_n = 1'b0;
    #1;
    check("t6_rst_valids", 64'({m_axi_awvalid, m_axi_wvalid, s_axis_tready, m_axi_bready, ctrl_done}), 64'd0);
    check("t6_rst_awaddr", m_axi_awaddr, 64'd0);
    check("t6_rst_awlen", 64'(m_axi_awlen), 64'd0);
    repeat (3) step();
    reset_n = 1'b1;
    clear_log();
    repeat (20) step();
    check("t6_no_done_after_abort", 64'(done_cnt), 64'd0);
    run_cmd(64'h3000, 64'd128);
    wait_done(500);
    check_common("t6", 1, 2);
    check_aw("t6", 0, 64'h3000, 8'd1);
    check("t6_last_strb", last_strb, 64'hFFFF_FFFF_FFFF_FFFF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/result_axi_writer.md
Name: result_axi_writer

Overview:
- Downstream stage of the result-copy engine.
- Accepts a transfer command (ctrl_start, byte address, byte count) and a 512-bit AXI4-Stream of result beats.
- Writes those beats to host memory through an AXI4 write master, splitting the transfer into INCR bursts that never cross a 4 KB boundary.
- Pulses ctrl_done once every burst has received its write response.

Parameters:
- MAX_BURST, 64, maximum beats per burst (1..256); awlen = beats-1.
- ADDR_W, 64, AXI address width.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- ctrl_start  in  1  single-cycle command pulse
- ctrl_done  out  1  single-cycle completion pulse
- ctrl_addr_offset  in  ADDR_W  destination byte address, sampled on ctrl_start
- ctrl_xfer_size_in_bytes  in  64  byte count, sampled on ctrl_start
- s_axis_tvalid  in  1  stream beat valid
- s_axis_tready  out  1  stream beat accept
- s_axis_tdata  in  512  stream payload
- m_axi_awvalid / m_axi_awready  out / in  1  write address handshake
- m_axi_awaddr  out  ADDR_W  burst start address
- m_axi_awlen  out  8  burst beats-1
- m_axi_awsize  out  3  constant 3'd6 (64 B)
- m_axi_awburst  out  2  constant 2'b01 (INCR)
- m_axi_wvalid / m_axi_wready  out / in  1  write data handshake
- m_axi_wdata  out  512  equals s_axis_tdata
- m_axi_wstrb  out  64  byte enables
- m_axi_wlast  out  1  last beat of burst
- m_axi_bvalid  in  1  write response valid
- m_axi_bready  out  1  write response accept

Behaviour:
- Reset (async assert, sync deassert by system): all valid/ready/done outputs 0, awaddr/awlen 0, state IDLE, counters 0. Reset mid-burst abandons the transfer silently; no ctrl_done.
- Command capture:
  - addr = ctrl_addr_offset with bits [5:0] forced to 0.
  - total_beats = ceil(size/64).
  - tail = size[5:0].
  - ctrl_start outside IDLE is ignored.
- FSM states: IDLE, ADDR, DATA, RESP, DONE.
  - IDLE: on ctrl_start, go to DONE if size==0, else go to ADDR.
  - ADDR: awvalid=1 and awlen = len-1, where len = min(remaining, MAX_BURST, (4096-addr[11:0])/64).
    - len is computed registered on ADDR entry and held stable while awvalid is high.
    - On awready, go to DATA.
  - DATA: wvalid = s_axis_tvalid and s_axis_tready = m_axi_wready (both combinational, this state only).
    - A beat transfers when tvalid && wready.
    - wlast is asserted on beat len-1 of the burst.
    - After the wlast beat transfers, go to RESP.
  - RESP: bready=1. On bvalid: addr += len*64 and remaining -= len. Then go to ADDR if remaining>0, else go to DONE.
  - DONE: ctrl_done=1 for exactly one cycle, then go to IDLE.
- Latency: ctrl_done for a zero-size command is asserted 2 cycles after ctrl_start.
- wstrb is all-ones, except on the final beat of the whole transfer when tail!=0, where it is (1<<tail)-1.
- One burst outstanding at a time; AW is never issued before the previous B is received.
- Stream beats beyond total_beats are not consumed (tready=0 outside DATA).
- bresp is ignored unless the optional feature is enabled.

Optional Feature:
- Macro: RESULT_AXI_WRITER_BRESP_CHECK_EN.
- When defined:
  - Adds input m_axi_bresp[1:0] and output wr_error (1 bit).
  - wr_error is sticky: set when bvalid && bresp!=2'b00, cleared on the next accepted ctrl_start and by reset.
- When undefined: neither port exists and responses are not checked.

Decomposition:
- Package result_axi_pkg:
  - Constants: DATA_W=512, BEAT_BYTES=64, AXSIZE_64B=3'd6, AXBURST_INCR=2'b01.
  - The state enum type.
- Sub-module result_axi_burst_len: combinational min(remaining, MAX_BURST, beats-to-4K) calculator, instantiated once.

Test Plan:
- offset 0, size 16384, MAX_BURST 64, always-ready slave -> 4 bursts, awaddr 0x0/0x1000/0x2000/0x3000, awlen 63, 256 beats total, one ctrl_done.
- offset 0xF80, size 256 -> burst 1: awaddr 0xF80, awlen 1; burst 2: awaddr 0x1000, awlen 1; wlast on beats 2 and 4.
- size 100 -> single burst, awlen 1, final wstrb 64'h0000000F_FFFFFFFF.
- size 0 -> no AW/W traffic, ctrl_done 2 cycles after ctrl_start.
- Random wready/tvalid gaps, and a second ctrl_start mid-transfer -> data order preserved, no beat dropped or duplicated, second start ignored.
- reset_n low during DATA, then new 128-byte command -> outputs 0 immediately; clean transfer afterwards: awlen 1, one ctrl_done.
